// File: rtl/alu_sched.sv
// Two-requester round-robin scheduler in front of one shared add/multiply ALU.
// One operation is in flight at a time: IDLE accepts, EXEC counts, RESP holds the result.
module alu_sched #(
  parameter int W       = 128,
  parameter int MUL_LAT = 4
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic [1:0]     req_v_i,
  input  logic [1:0]     req_op_i,
  input  logic [2*W-1:0] req_a_i,
  input  logic [2*W-1:0] req_b_i,
  output logic [1:0]     req_ready_o,
  output logic           resp_v_o,
  input  logic           resp_ready_i,
  output logic           resp_id_o,
  output logic [W-1:0]   resp_data_o,
  output logic           busy_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid may drop before acceptance, and RESP holds its outputs
  // unchanged until resp_ready_i completes the transfer.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           last_q, last_d;
  logic           op_q, op_d;
  logic           id_q, id_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   data_q, data_d;
  logic           gnt_id;
  logic [W-1:0]   alu_res;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    gnt_id = 1'b0;
    if (req_v_i == 2'b11) begin
      gnt_id = ~last_q;
    end else if (req_v_i[1]) begin
      gnt_id = 1'b1;
    end
  end

  // Modulo-2^W add and multiply; high bits are simply dropped.
  always_comb begin
    if (op_q) begin
      alu_res = a_q * b_q;
    end else begin
      alu_res = a_q + b_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    op_d        = op_q;
    id_d        = id_q;
    a_d         = a_q;
    b_d         = b_q;
    data_d      = data_q;
    req_ready_o = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (|req_v_i) begin
          req_ready_o = gnt_id ? 2'b10 : 2'b01;
          state_d     = S_EXEC;
          op_d        = req_op_i[gnt_id];
          a_d         = req_a_i[gnt_id*W +: W];
          b_d         = req_b_i[gnt_id*W +: W];
          id_d        = gnt_id;
          last_d      = gnt_id;
          cnt_d       = req_op_i[gnt_id] ? 4'(MUL_LAT - 1) : 4'd0;
        end
      end
      S_EXEC: begin
        if (cnt_q == 4'd0) begin
          data_d  = alu_res;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (resp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      last_q  <= 1'b1;
      op_q    <= 1'b0;
      id_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      op_q    <= op_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
    end
  end

  assign resp_v_o    = (state_q == S_RESP);
  assign busy_o      = (state_q != S_IDLE);
  assign resp_id_o   = id_q;
  assign resp_data_o = data_q;

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched: latency, wrap, round-robin, backpressure, async reset.
module tb_alu_sched;
  localparam int W = 128;

  logic           clk_i;
  logic           reset_i;
  logic [1:0]     req_v_i;
  logic [1:0]     req_op_i;
  logic [2*W-1:0] req_a_i;
  logic [2*W-1:0] req_b_i;
  logic [1:0]     req_ready_o;
  logic           resp_v_o;
  logic           resp_ready_i;
  logic           resp_id_o;
  logic [W-1:0]   resp_data_o;
  logic           busy_o;

  int checks = 0;
  int errors = 0;

  alu_sched #(.W(W), .MUL_LAT(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_v_i(req_v_i), .req_op_i(req_op_i),
    .req_a_i(req_a_i), .req_b_i(req_b_i),
    .req_ready_o(req_ready_o),
    .resp_v_o(resp_v_o), .resp_ready_i(resp_ready_i),
    .resp_id_o(resp_id_o), .resp_data_o(resp_data_o),
    .busy_o(busy_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: presents one request, checks its grant, holds it through the accept edge.
  task automatic issue(input int n, input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    req_v_i[n]          = 1'b1;
    req_op_i[n]         = op;
    req_a_i[n*W +: W]   = a;
    req_b_i[n*W +: W]   = b;
    #1;
    chk("grant", W'(req_ready_o), (n == 1) ? W'(2) : W'(1));
    @(posedge clk_i);
    #1;
    req_v_i = 2'b00;
  endtask

  // Counts cycles after the accept edge until resp_v_o is seen at a negedge (bounded).
  task automatic wait_resp(output int lat);
    lat = 1;
    @(negedge clk_i);
    while (!resp_v_o && lat < 20) begin
      @(negedge clk_i);
      lat++;
    end
  endtask

  logic [W-1:0] hold_data;
  logic [1:0]   exp_rdy;
  int           lat;

  initial begin
    reset_i      = 1'b1;
    req_v_i      = 2'b00;
    req_op_i     = 2'b00;
    req_a_i      = '0;
    req_b_i      = '0;
    resp_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("rst_resp_v", W'(resp_v_o), 0);
    chk("rst_data", resp_data_o, 0);
    chk("rst_id", W'(resp_id_o), 0);
    chk("rst_busy", W'(busy_o), 0);
    chk("rst_ready", W'(req_ready_o), 0);

    // Contention straight out of reset: grants alternate 0,1,0,1.
    req_op_i = 2'b00;
    req_a_i  = {W'(10), W'(1)};
    req_b_i  = {W'(20), W'(2)};
    reset_i  = 1'b0;
    req_v_i  = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      chk("rr_ready", W'(req_ready_o), W'(exp_rdy));
      @(posedge clk_i);
      wait_resp(lat);
      chk("rr_lat", W'(lat), 2);
      chk("rr_id", W'(resp_id_o), (i % 2 == 0) ? W'(0) : W'(1));
      chk("rr_data", resp_data_o, (i % 2 == 0) ? W'(3) : W'(30));
      @(negedge clk_i);
    end
    req_v_i = 2'b00;
    @(negedge clk_i);
    chk("rr_idle_busy", W'(busy_o), 0);

    // Single add.
    issue(0, 1'b0, W'(5), W'(7));
    wait_resp(lat);
    chk("add_lat", W'(lat), 2);
    chk("add_data", resp_data_o, W'(12));
    chk("add_id", W'(resp_id_o), 0);
    @(negedge clk_i);

    // Multiply with wrap, then a plain multiply.
    issue(1, 1'b1, W'(1) << 127, W'(2));
    wait_resp(lat);
    chk("mulw_lat", W'(lat), 5);
    chk("mulw_data", resp_data_o, 0);
    chk("mulw_id", W'(resp_id_o), 1);
    @(negedge clk_i);
    issue(1, 1'b1, W'(3), W'(5));
    wait_resp(lat);
    chk("mul_lat", W'(lat), 5);
    chk("mul_data", resp_data_o, W'(15));
    chk("mul_id", W'(resp_id_o), 1);
    @(negedge clk_i);

    // Add overflow.
    issue(0, 1'b0, {W{1'b1}}, W'(1));
    wait_resp(lat);
    chk("ovf_lat", W'(lat), 2);
    chk("ovf_data", resp_data_o, 0);
    @(negedge clk_i);

    // Backpressure: outputs hold while resp_ready_i is low, requests are refused.
    resp_ready_i = 1'b0;
    issue(1, 1'b0, W'(100), W'(23));
    wait_resp(lat);
    chk("bp_lat", W'(lat), 2);
    chk("bp_data0", resp_data_o, W'(123));
    hold_data = resp_data_o;
    req_v_i   = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("bp_resp_v", W'(resp_v_o), 1);
      chk("bp_data", resp_data_o, W'(123));
      chk("bp_id", W'(resp_id_o), 1);
      chk("bp_ready", W'(req_ready_o), 0);
      chk("bp_busy", W'(busy_o), 1);
    end
    req_v_i      = 2'b00;
    resp_ready_i = 1'b1;
    @(negedge clk_i);
    chk("bp_release", W'(busy_o), 0);

    // Reset in the second EXEC cycle of a multiply.
    issue(0, 1'b1, W'(6), W'(7));
    @(negedge clk_i);
    chk("mr_busy_exec", W'(busy_o), 1);
    @(posedge clk_i);
    #2;
    reset_i = 1'b1;
    #1;
    chk("mr_resp_v_async", W'(resp_v_o), 0);
    chk("mr_busy_async", W'(busy_o), 0);
    @(negedge clk_i);
    reset_i = 1'b0;
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      if (resp_v_o || busy_o) lat++;
    end
    chk("mr_no_late_resp", W'(lat), 0);
    req_v_i = 2'b11;
    #1;
    chk("mr_tie_after_reset", W'(req_ready_o), W'(2'b01));
    req_v_i = 2'b00;
    @(negedge clk_i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
